// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry flop,
// LSB-first, WIDTH cycles per operation with a start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] r_sh_reg;
   logic [WIDTH-1:0] b_cond;
   logic [CNT_W-1:0] cnt_reg;
   logic             carry_reg;
   logic             op_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             load;
   logic             last;
   logic             fa_s;
   logic             fa_c;

   // Subtraction feeds the inverted B operand; the +1 comes from presetting the carry.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bcond
         assign b_cond[gi] = b[gi] ^ op;
      end
   endgenerate

   assign load = (state_reg != SHIFT) && start;
   assign last = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);

   assign fa_s = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
   assign fa_c = (a_sh_reg[0] & b_sh_reg[0]) |
                 (a_sh_reg[0] & carry_reg)   |
                 (b_sh_reg[0] & carry_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = DONE;
         DONE:    state_next = start ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         r_sh_reg  <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         op_reg    <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (load) begin
         a_sh_reg  <= a;
         b_sh_reg  <= b_cond;
         carry_reg <= op;
         op_reg    <= op;
         cnt_reg   <= '0;
      end else if (state_reg == SHIFT) begin
         a_sh_reg  <= a_sh_reg >> 1;
         b_sh_reg  <= b_sh_reg >> 1;
         r_sh_reg  <= {fa_s, r_sh_reg[WIDTH-1:1]};
         carry_reg <= fa_c;
         cnt_reg   <= cnt_reg + CNT_W'(1);
         // On the MSB cycle carry_reg still holds the carry into the MSB.
         if (last) begin
            sum_reg  <= {fa_s, r_sh_reg[WIDTH-1:1]};
            cout_reg <= op_reg ^ fa_c;
            ovf_reg  <= carry_reg ^ fa_c;
         end
      end
   end

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=8 directed vectors plus WIDTH=4 exhaustive sweep,
// checked every cycle against a cycle-count/arithmetic model.
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       start8, op8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start4, op4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .reset_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result as {ovf, cout, sum[7:0]} from signed/unsigned integer arithmetic.
   function automatic logic [9:0] ref_op(input int w, input logic op, input int a, input int b);
      int full, lim, sa, sb, sres;
      logic [9:0] r;
      full = 1 << w;
      lim  = full / 2;
      sa   = (a >= lim) ? a - full : a;
      sb   = (b >= lim) ? b - full : b;
      sres = op ? sa - sb : sa + sb;
      r       = '0;
      r[7:0]  = 8'((op ? a - b : a + b) & (full - 1));
      r[8]    = op ? (a < b) : ((a + b) >= full);
      r[9]    = (sres < -lim) || (sres >= lim);
      return r;
   endfunction

   // Model: an accepted start yields a result exactly w edges later, then one done cycle.
   int         rem8, rem4;
   logic [9:0] pend8, pend4, out8, out4;
   logic       dm8, dm4;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem8 <= 0; out8 <= '0; dm8 <= 1'b0;
      end else if (rem8 > 0) begin
         rem8 <= rem8 - 1;
         if (rem8 == 1) begin
            out8 <= pend8;
            dm8  <= 1'b1;
         end
      end else begin
         dm8 <= 1'b0;
         if (start8) begin
            rem8  <= 8;
            pend8 <= ref_op(8, op8, int'(a8), int'(b8));
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem4 <= 0; out4 <= '0; dm4 <= 1'b0;
      end else if (rem4 > 0) begin
         rem4 <= rem4 - 1;
         if (rem4 == 1) begin
            out4 <= pend4;
            dm4  <= 1'b1;
         end
      end else begin
         dm4 <= 1'b0;
         if (start4) begin
            rem4  <= 4;
            pend4 <= ref_op(4, op4, int'(a4), int'(b4));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy8", int'(busy8), int'(rem8 > 0));
         chk("done8", int'(done8), int'(dm8));
         chk("sum8",  int'(sum8),  int'(out8[7:0]));
         chk("cout8", int'(cout8), int'(out8[8]));
         chk("ovf8",  int'(ovf8),  int'(out8[9]));
         chk("busy_and_done8", int'(busy8 && done8), 0);
         chk("busy4", int'(busy4), int'(rem4 > 0));
         chk("done4", int'(done4), int'(dm4));
         chk("sum4",  int'(sum4),  int'(out4[3:0]));
         chk("cout4", int'(cout4), int'(out4[8]));
         chk("ovf4",  int'(ovf4),  int'(out4[9]));
      end
   end

   task automatic wait_done8(output int n);
      n = 0;
      while (!done8 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run8(input string name, input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec, input logic ev);
      int n;
      @(negedge clk);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(n);
      chk({name, "_latency"}, n, 8);
      chk({name, "_sum"},  int'(sum8),  int'(es));
      chk({name, "_cout"}, int'(cout8), int'(ec));
      chk({name, "_ovf"},  int'(ovf8),  int'(ev));
      $display("%s op=%0d a=%h b=%h sum=%h cout=%0d ovf=%0d latency=%0d",
               name, op, a, b, sum8, cout8, ovf8, n);
   endtask

   task automatic run4(input logic op, input logic [3:0] a, input logic [3:0] b);
      int n;
      logic [9:0] e;
      e = ref_op(4, op, int'(a), int'(b));
      @(negedge clk);
      start4 = 1'b1; op4 = op; a4 = a; b4 = b;
      @(posedge clk); #1;
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w4_latency", n, 4);
      chk("w4_sum",  int'(sum4),  int'(e[3:0]));
      chk("w4_cout", int'(cout4), int'(e[8]));
      chk("w4_ovf",  int'(ovf4),  int'(e[9]));
      $display("w4 op=%0d a=%h b=%h sum=%h cout=%0d ovf=%0d latency=%0d",
               op, a, b, sum4, cout4, ovf4, n);
   endtask

   initial begin
      int n, cnt;
      rst_n = 1'b0;
      start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0;
      #1;
      chk("reset_busy", int'(busy8), 0);
      chk("reset_done", int'(done8), 0);
      chk("reset_sum",  int'(sum8),  0);
      chk("reset_cout", int'(cout8), 0);
      chk("reset_ovf",  int'(ovf8),  0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run8("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      run8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      run8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
      run8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run8("sub_33_33", 1'b1, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0);

      // start during SHIFT must be ignored and leave sum untouched
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("ignore_sum_stable", int'(sum8), 8'h00);
      wait_done8(n);
      chk("ignore_latency", n, 5);
      chk("ignore_sum", int'(sum8), 8'h46);
      $display("ignore op=0 a=12 b=34 sum=%h cout=%0d ovf=%0d", sum8, cout8, ovf8);

      // start in the DONE cycle: next done 9 cycles after the first
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(n);
      chk("b2b_first_sum", int'(sum8), 8'h30);
      start8 = 1'b1; op8 = 1'b1; a8 = 8'h50; b8 = 8'h10;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_gap", n, 9);
      chk("b2b_second_sum", int'(sum8), 8'h40);
      $display("b2b op=1 a=50 b=10 sum=%h gap=%0d", sum8, n);

      // start held high: one launch every 9 cycles
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
      cnt = 0;
      repeat (27) begin
         @(posedge clk); #1;
         if (done8) cnt++;
      end
      start8 = 1'b0;
      chk("held_start_dones", cnt, 3);
      chk("held_start_sum", int'(sum8), 8'h02);
      $display("held_start dones=%0d sum=%h", cnt, sum8);
      repeat (10) @(posedge clk);

      // asynchronous reset in the middle of an operation
      run8("pre_reset", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", int'(busy8), 0);
      chk("midreset_done", int'(done8), 0);
      chk("midreset_sum",  int'(sum8),  0);
      chk("midreset_cout", int'(cout8), 0);
      chk("midreset_ovf",  int'(ovf8),  0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done8) cnt++;
      end
      chk("midreset_no_done", cnt, 0);
      $display("midreset aborted dones=%0d sum=%h", cnt, sum8);
      run8("post_reset", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

      for (int o = 0; o < 2; o++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               run4(o[0], 4'(x), 4'(y));

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
